// File: rtl/cordic_sincos_iter_if.sv
// Request/result bundle for the iterative CORDIC sin/cos unit.
// master: start, angle_deg out; busy, done, angle_err, cos_out, sin_out in.
interface cordic_sincos_iter_if #(
   parameter int WIDTH = 16
);
   logic                    start;
   logic [8:0]              angle_deg;
   logic                    busy;
   logic                    done;
   logic                    angle_err;
   logic signed [WIDTH-1:0] cos_out;
   logic signed [WIDTH-1:0] sin_out;

   modport master (
      output start, angle_deg,
      input  busy, done, angle_err, cos_out, sin_out
   );

   modport slave (
      input  start, angle_deg,
      output busy, done, angle_err, cos_out, sin_out
   );
endinterface

// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC: degree angle -> signed Q1.14 cos/sin.
// Ports: clk, reset (sync, active-high), bus (slave: start, angle_deg,
// busy, done, angle_err, cos_out, sin_out).
// Option: CORDIC_ROUND_EN rounds half-up when dropping guard bits.
module cordic_sincos_iter #(
   parameter int ITER  = 14,
   parameter int WIDTH = 16,
   parameter int GUARD = 2
) (
   input logic                 clk,
   input logic                 reset,
   cordic_sincos_iter_if.slave bus
);
   localparam int IW = WIDTH + GUARD;
   localparam int IB = $clog2(ITER);
   localparam int X0I = $rtoi(0.6072529 * (2.0 ** (WIDTH - 2 + GUARD)) + 0.5);
   localparam logic signed [IW-1:0] X0 = IW'(X0I);
   localparam logic signed [IW:0] PMAX = (IW+1)'(1 << (WIDTH - 2));
   localparam logic signed [IW:0] NMAX = -PMAX;
`ifdef CORDIC_ROUND_EN
   localparam logic signed [IW:0] RND = (IW+1)'(1 << (GUARD - 1));
`endif

   typedef enum logic [1:0] {IDLE, LOAD, ROT, FINAL} state_t;

   state_t                  state, state_nx;
   logic [8:0]              a;
   logic signed [IW-1:0]    x, y;
   logic signed [23:0]      z;
   logic [IB-1:0]           i;
   logic                    neg;
   logic                    err_r;
   logic signed [WIDTH-1:0] cos_r, sin_r;

   logic signed [IW-1:0]    sh_x, sh_y, x_rot, y_rot;
   logic signed [23:0]      z_rot, at;
   logic signed [9:0]       theta;
   logic                    neg_c, a_bad, last;
   logic signed [WIDTH-1:0] fin_cos, fin_sin;

   function automatic logic signed [23:0] atan_rom(input logic [3:0] k);
      logic signed [23:0] r;
      case (k)
         4'd0:    r = 24'sd737280;
         4'd1:    r = 24'sd435242;
         4'd2:    r = 24'sd229970;
         4'd3:    r = 24'sd116736;
         4'd4:    r = 24'sd58595;
         4'd5:    r = 24'sd29326;
         4'd6:    r = 24'sd14667;
         4'd7:    r = 24'sd7334;
         4'd8:    r = 24'sd3667;
         4'd9:    r = 24'sd1833;
         4'd10:   r = 24'sd917;
         4'd11:   r = 24'sd458;
         4'd12:   r = 24'sd229;
         4'd13:   r = 24'sd115;
         4'd14:   r = 24'sd57;
         default: r = 24'sd29;
      endcase
      return r;
   endfunction

   // Drop guard bits, undo the half-plane fold, clamp to +/-1.0.
   function automatic logic signed [WIDTH-1:0] finish(
      input logic signed [IW-1:0] v,
      input logic                 ng
   );
      logic signed [IW:0] t;
      t = {v[IW-1], v};
`ifdef CORDIC_ROUND_EN
      t = t + RND;
`endif
      t = t >>> GUARD;
      if (ng)
         t = -t;
      if (t > PMAX)
         t = PMAX;
      else if (t < NMAX)
         t = NMAX;
      return t[WIDTH-1:0];
   endfunction

   always_comb begin
      a_bad = (a >= 9'd360);
      neg_c = 1'b0;
      theta = 10'(a);
      if (a <= 9'd90) begin
         theta = 10'(a);
      end else if (a < 9'd270) begin
         theta = 10'(a) - 10'd180;
         neg_c = 1'b1;
      end else begin
         theta = 10'(a) - 10'd360;
      end
   end

   always_comb begin
      sh_x = x >>> i;
      sh_y = y >>> i;
      at   = atan_rom(4'(i));
      last = (i == IB'(ITER - 1));
      if (!z[23]) begin
         x_rot = x - sh_y;
         y_rot = y + sh_x;
         z_rot = z - at;
      end else begin
         x_rot = x + sh_y;
         y_rot = y - sh_x;
         z_rot = z + at;
      end
      fin_cos = finish(x_rot, neg);
      fin_sin = finish(y_rot, neg);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.start) state_nx = LOAD;
         LOAD:    state_nx = a_bad ? FINAL : ROT;
         ROT:     if (last) state_nx = FINAL;
         FINAL:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         a     <= '0;
         x     <= '0;
         y     <= '0;
         z     <= '0;
         i     <= '0;
         neg   <= 1'b0;
         err_r <= 1'b0;
         cos_r <= '0;
         sin_r <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a     <= bus.angle_deg;
                  err_r <= 1'b0;
               end
            end
            LOAD: begin
               x   <= X0;
               y   <= '0;
               z   <= {theta, 14'b0};
               i   <= '0;
               neg <= neg_c;
               if (a_bad) begin
                  cos_r <= '0;
                  sin_r <= '0;
                  err_r <= 1'b1;
               end
            end
            ROT: begin
               x <= x_rot;
               y <= y_rot;
               z <= z_rot;
               i <= i + IB'(1);
               // Results land on the edge into FINAL so they align with done.
               if (last) begin
                  cos_r <= fin_cos;
                  sin_r <= fin_sin;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state == LOAD) || (state == ROT);
   assign bus.done      = (state == FINAL);
   assign bus.angle_err = err_r;
   assign bus.cos_out   = cos_r;
   assign bus.sin_out   = sin_r;
endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Directed bench for cordic_sincos_iter: latency, accuracy, error,
// ignored starts, mid-calculation reset.
module tb_cordic_sincos_iter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   lat, bcnt, dcnt;

   always #5 clk = ~clk;

   cordic_sincos_iter_if #(.WIDTH(16)) bus ();

   cordic_sincos_iter #(
      .ITER (14),
      .WIDTH(16),
      .GUARD(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input int got, input int exp,
                        input int tol = 0);
      n_cmp++;
      if (got > exp + tol || got < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)",
                  tag, got, exp, tol);
      end
   endtask

   // Start is high in cycle 0; lat counts cycles until done is seen.
   task automatic run(input int a, input int a2, input int at2,
                      output int lt, output int bc);
      int n;
      int seen;
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.angle_deg = 9'(a);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n    = 1;
      bc   = 0;
      seen = 0;
      while (n < 40) begin
         @(negedge clk);
         if (bus.busy) bc++;
         if (bus.done) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         n++;
         #1;
         if (n == at2) begin
            bus.start     = 1'b1;
            bus.angle_deg = 9'(a2);
         end else begin
            bus.start = 1'b0;
         end
      end
      lt = n;
      check("done_seen", seen, 1);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.angle_deg = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_err", int'(bus.angle_err), 0);
      check("rst_cos", int'(bus.cos_out), 0);
      check("rst_sin", int'(bus.sin_out), 0);

      run(0, 0, 0, lat, bcnt);
      check("a0_lat", lat, 16);
      check("a0_cos", int'(bus.cos_out), 16384, 3);
      check("a0_sin", int'(bus.sin_out), 0, 3);
      check("a0_err", int'(bus.angle_err), 0);
      check("a0_busy", bcnt, 15);

      run(90, 0, 0, lat, bcnt);
      check("a90_lat", lat, 16);
      check("a90_cos", int'(bus.cos_out), 0, 3);
      check("a90_sin", int'(bus.sin_out), 16384, 3);

      run(180, 0, 0, lat, bcnt);
      check("a180_cos", int'(bus.cos_out), -16384, 3);
      check("a180_sin", int'(bus.sin_out), 0, 3);

      run(270, 0, 0, lat, bcnt);
      check("a270_cos", int'(bus.cos_out), 0, 3);
      check("a270_sin", int'(bus.sin_out), -16384, 3);

      run(36, 0, 0, lat, bcnt);
      check("a36_cos", int'(bus.cos_out), 13255, 3);
      check("a36_sin", int'(bus.sin_out), 9630, 3);
      @(negedge clk);
      check("done_pulse", int'(bus.done), 0);
      repeat (3) @(negedge clk);
      check("hold_cos", int'(bus.cos_out), 13255, 3);
      check("hold_sin", int'(bus.sin_out), 9630, 3);

      run(198, 0, 0, lat, bcnt);
      check("a198_cos", int'(bus.cos_out), -15582, 3);
      check("a198_sin", int'(bus.sin_out), -5063, 3);

      run(400, 0, 0, lat, bcnt);
      check("e400_lat", lat, 2);
      check("e400_err", int'(bus.angle_err), 1);
      check("e400_cos", int'(bus.cos_out), 0);
      check("e400_sin", int'(bus.sin_out), 0);
      @(negedge clk);
      check("e400_hold", int'(bus.angle_err), 1);

      run(0, 0, 0, lat, bcnt);
      check("clr_lat", lat, 16);
      check("clr_err", int'(bus.angle_err), 0);
      check("clr_cos", int'(bus.cos_out), 16384, 3);

      run(90, 0, 5, lat, bcnt);
      check("ign_lat", lat, 16);
      check("ign_busy", bcnt, 15);
      check("ign_cos", int'(bus.cos_out), 0, 3);
      check("ign_sin", int'(bus.sin_out), 16384, 3);
      repeat (20) begin
         @(negedge clk);
         check("ign_noq", int'(bus.done), 0);
      end

      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.angle_deg = 9'd90;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_cos", int'(bus.cos_out), 0);
      check("abort_sin", int'(bus.sin_out), 0);
      dcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) dcnt++;
      end
      check("abort_nodone", dcnt, 0);

      run(180, 0, 0, lat, bcnt);
      check("post_lat", lat, 16);
      check("post_cos", int'(bus.cos_out), -16384, 3);
      check("post_sin", int'(bus.sin_out), 0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_cmp, n_fail);
      $finish;
   end
endmodule
